// File: rtl/spi_pkg.sv
// Shared SPI frame definitions: address width, header length and controller FSM states.
package spi_pkg;

  localparam int ADDR_W = 7;
  // Header is the R/W bit followed by the register address.
  localparam int HDR_W  = 1 + ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP
  } spi_state_e;

  function automatic int frame_len(input int data_w);
    return HDR_W + data_w;
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period timer: counts CLK_DIV cycles while enabled and strobes on the last one.
module spi_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic phase_end
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  assign phase_end = en && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt <= '0;
    end else if (phase_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 controller: sends one {rw, addr, wdata} frame MSB first and captures the data-phase CIPO bits.
// Handshake: start is taken only while idle (busy=0); done pulses for one cycle as busy drops, and a start in that cycle is taken.
module spi_controller
  import spi_pkg::*;
#(
  parameter int W       = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [W-1:0]      wdata,
  output logic              busy,
  output logic              done,
  output logic [W-1:0]      rdata,
  output logic              SCLK,
  output logic              nCS,
  output logic              COPI,
  input  logic              CIPO
);

  localparam int FRAME_W = frame_len(W);
  localparam int BIT_W   = $clog2(FRAME_W);

  spi_state_e          state, state_next;
  logic                phase_end;
  logic                accept;
  logic                last_bit;
  logic [BIT_W-1:0]    bit_cnt;
  // Bits still to send after the one currently on COPI.
  logic [FRAME_W-2:0]  tx;
  logic [W-1:0]        rx;
  logic [FRAME_W-1:0]  frame;

  assign frame    = {rw, addr, wdata};
  assign accept   = (state == IDLE) && start && !busy;
  assign last_bit = (bit_cnt == BIT_W'(FRAME_W - 1));

  spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state != IDLE),
    .phase_end (phase_end)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept)    state_next = SETUP;
      SETUP:    if (phase_end) state_next = SHIFT_HI;
      SHIFT_HI: if (phase_end) state_next = last_bit ? HOLD : SHIFT_LO;
      SHIFT_LO: if (phase_end) state_next = SHIFT_HI;
      HOLD:     if (phase_end) state_next = GAP;
      GAP:      if (phase_end) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      SCLK    <= 1'b0;
      nCS     <= 1'b1;
      COPI    <= 1'b0;
      bit_cnt <= '0;
      tx      <= '0;
      rx      <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      SCLK  <= (state_next == SHIFT_HI);
      nCS   <= !(state_next inside {SETUP, SHIFT_HI, SHIFT_LO, HOLD});
      done  <= (state == GAP) && phase_end;

      if (accept) begin
        tx      <= frame[FRAME_W-2:0];
        COPI    <= frame[FRAME_W-1];
        bit_cnt <= '0;
        rx      <= '0;
      end

      if ((state == SHIFT_HI) && phase_end) begin
        if (bit_cnt >= BIT_W'(HDR_W)) begin
          rx <= {rx[W-2:0], CIPO};
        end
        if (!last_bit) begin
          COPI    <= tx[FRAME_W-2];
          tx      <= {tx[FRAME_W-3:0], 1'b0};
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end

      if ((state == HOLD) && phase_end) begin
        COPI <= 1'b0;
      end

      if ((state == GAP) && phase_end) begin
        rdata <= rx;
      end
    end
  end

endmodule
